// File: rtl/irf_window_seq_if.sv
// rtl/irf_window_seq_if.sv - request/strobe bundle between core threads and the window sequencer
//
// Purpose: carries the per-thread window-change requests into irf_window_seq and
// the register-file strobes, acks, busy flags and CWP values back out.
// Signals:
//   req_vld[3:0]       per-thread request valid, held until ack
//   req_op[7:0]        2-bit op per thread (01 SAVE, 10 RESTORE, 11 WRCWP, 00 no-op)
//   req_cwp[11:0]      3-bit WRCWP target per thread
//   ack[3:0]           one-cycle one-hot completion pulse
//   busy_th[3:0]       thread's live window is in transition
//   save, save_addr    register-file save strobe and {tid, old_cwp}
//   restore, restore_addr  register-file restore strobe and {tid, new_cwp}
//   cwp[11:0]          current window pointer per thread
// Modports: master = core side (drives requests), slave = sequencer.
interface irf_window_seq_if;
  logic [3:0]  req_vld;
  logic [7:0]  req_op;
  logic [11:0] req_cwp;
  logic [3:0]  ack;
  logic [3:0]  busy_th;
  logic        save;
  logic [4:0]  save_addr;
  logic        restore;
  logic [4:0]  restore_addr;
  logic [11:0] cwp;

  modport master (
    output req_vld, req_op, req_cwp,
    input  ack, busy_th, save, save_addr, restore, restore_addr, cwp
  );

  modport slave (
    input  req_vld, req_op, req_cwp,
    output ack, busy_th, save, save_addr, restore, restore_addr, cwp
  );
endinterface

// File: rtl/irf_window_seq.sv
// rtl/irf_window_seq.sv - register-window change sequencer for the 4-thread integer register file
//
// Purpose: round-robin arbitrates SAVE / RESTORE / WRCWP requests from 4 threads,
// issues a one-cycle save of the old window then a one-cycle restore of the new
// window, updates that thread's CWP and pulses ack. The owning thread is flagged
// busy from the save cycle through the ack cycle.
// Ports:
//   clk    core clock, all state on posedge
//   rst_l  asynchronous active-low reset
//   bus    irf_window_seq_if.slave (requests in; strobes, acks, busy, cwp out)
// Parameters:
//   NWIN     windows per thread (power of two, <= 8); CWP arithmetic is modulo NWIN
//   RST_CWP  CWP loaded into every thread at reset
module irf_window_seq #(
  parameter int NWIN    = 8,
  parameter int RST_CWP = 0
) (
  input  logic              clk,
  input  logic              rst_l,
  irf_window_seq_if.slave   bus
);

  localparam logic [2:0] CWP_MASK = 3'(NWIN - 1);
  localparam logic [2:0] CWP_RST  = 3'(RST_CWP) & CWP_MASK;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2,
    ST_ACK     = 2'd3
  } state_t;

  state_t      r_state;
  logic [1:0]  r_ptr;
  logic [1:0]  r_tid;
  logic [2:0]  r_new_cwp;
  logic [2:0]  r_cwp [4];
  logic [3:0]  r_ack;
  logic [3:0]  r_busy;
  logic        r_save;
  logic        r_restore;
  logic [4:0]  r_save_addr;
  logic [4:0]  r_restore_addr;

  logic        w_gnt_vld;
  logic [1:0]  w_gnt_tid;
  logic [1:0]  w_op;
  logic [2:0]  w_cur_cwp;
  logic [2:0]  w_req_cwp;
  logic [2:0]  w_new_cwp;
  logic        w_no_change;

  // Scan from the highest offset down so the requester closest to the pointer
  // is the last (winning) assignment.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_tid = r_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (bus.req_vld[r_ptr + 2'(i)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_tid = r_ptr + 2'(i);
      end
    end
  end

  always_comb begin
    w_op      = bus.req_op[{w_gnt_tid, 1'b0} +: 2];
    w_cur_cwp = r_cwp[w_gnt_tid];
    w_req_cwp = bus.req_cwp[{2'b00, w_gnt_tid} * 4'd3 +: 3];
    case (w_op)
      2'b01:   w_new_cwp = (w_cur_cwp + 3'd1) & CWP_MASK;
      2'b10:   w_new_cwp = (w_cur_cwp - 3'd1) & CWP_MASK;
      2'b11:   w_new_cwp = w_req_cwp & CWP_MASK;
      default: w_new_cwp = w_cur_cwp;
    endcase
    // Nothing to move: skip the save/restore pair and ack straight away.
    w_no_change = (w_op == 2'b00) || (w_new_cwp == w_cur_cwp);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state        <= ST_IDLE;
      r_ptr          <= 2'd0;
      r_tid          <= 2'd0;
      r_new_cwp      <= 3'd0;
      r_ack          <= 4'b0000;
      r_busy         <= 4'b0000;
      r_save         <= 1'b0;
      r_restore      <= 1'b0;
      r_save_addr    <= 5'd0;
      r_restore_addr <= 5'd0;
      for (int t = 0; t < 4; t++) r_cwp[t] <= CWP_RST;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_vld) begin
            r_tid     <= w_gnt_tid;
            r_new_cwp <= w_new_cwp;
            r_ptr     <= w_gnt_tid + 2'd1;
            r_busy    <= 4'b0001 << w_gnt_tid;
            if (w_no_change) begin
              r_ack   <= 4'b0001 << w_gnt_tid;
              r_state <= ST_ACK;
            end else begin
              r_save      <= 1'b1;
              r_save_addr <= {w_gnt_tid, w_cur_cwp};
              r_state     <= ST_SAVE;
            end
          end
        end
        ST_SAVE: begin
          // save_addr is left untouched so the register file can sample it
          // one cycle late, during RESTORE.
          r_save         <= 1'b0;
          r_restore      <= 1'b1;
          r_restore_addr <= {r_tid, r_new_cwp};
          r_state        <= ST_RESTORE;
        end
        ST_RESTORE: begin
          r_restore    <= 1'b0;
          r_cwp[r_tid] <= r_new_cwp;
          r_ack        <= 4'b0001 << r_tid;
          r_state      <= ST_ACK;
        end
        ST_ACK: begin
          r_ack   <= 4'b0000;
          r_busy  <= 4'b0000;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ack          = r_ack;
  assign bus.busy_th      = r_busy;
  assign bus.save         = r_save;
  assign bus.save_addr    = r_save_addr;
  assign bus.restore      = r_restore;
  assign bus.restore_addr = r_restore_addr;
  assign bus.cwp          = {r_cwp[3], r_cwp[2], r_cwp[1], r_cwp[0]};

  // A thread raising a new request while its window is still in transition.
  a_req_while_busy: assert property (@(posedge clk) disable iff (!rst_l)
    ((bus.req_vld & ~$past(bus.req_vld) & bus.busy_th) == 4'b0000));

endmodule

// File: tb/tb_irf_window_seq.sv
// tb/tb_irf_window_seq.sv - directed self-checking bench for irf_window_seq
module tb_irf_window_seq;
  logic clk = 1'b0;
  logic rst_l;
  int   checks   = 0;
  int   failures = 0;
  logic [2:0] m_cwp [4];

  irf_window_seq_if bus ();

  irf_window_seq #(.NWIN(8), .RST_CWP(0)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] m_pack();
    return {m_cwp[3], m_cwp[2], m_cwp[1], m_cwp[0]};
  endfunction

  task automatic check_quiet(input string tag);
    check_eq({tag, "_ack"},     32'(bus.ack),     32'h0);
    check_eq({tag, "_busy"},    32'(bus.busy_th), 32'h0);
    check_eq({tag, "_save"},    32'(bus.save),    32'h0);
    check_eq({tag, "_restore"}, 32'(bus.restore), 32'h0);
  endtask

  // Drive a request at a negedge (cycle 0) and check every following cycle.
  task automatic op_cycle(input int tid, input logic [1:0] op, input logic [2:0] tgt,
                          input logic [2:0] old_c, input logic [2:0] new_c, input bit chg);
    logic [3:0] oh;
    oh = 4'(1 << tid);
    bus.req_op[2*tid +: 2]  = op;
    bus.req_cwp[3*tid +: 3] = tgt;
    bus.req_vld[tid]        = 1'b1;
    @(negedge clk);
    if (chg) begin
      check_eq($sformatf("t%0d_c1_save", tid),      32'(bus.save),      32'h1);
      check_eq($sformatf("t%0d_c1_save_addr", tid), 32'(bus.save_addr), 32'({2'(tid), old_c}));
      check_eq($sformatf("t%0d_c1_restore", tid),   32'(bus.restore),   32'h0);
      check_eq($sformatf("t%0d_c1_busy", tid),      32'(bus.busy_th),   32'(oh));
      check_eq($sformatf("t%0d_c1_ack", tid),       32'(bus.ack),       32'h0);
      @(negedge clk);
      check_eq($sformatf("t%0d_c2_save", tid),         32'(bus.save),         32'h0);
      check_eq($sformatf("t%0d_c2_restore", tid),      32'(bus.restore),      32'h1);
      check_eq($sformatf("t%0d_c2_restore_addr", tid), 32'(bus.restore_addr), 32'({2'(tid), new_c}));
      check_eq($sformatf("t%0d_c2_save_addr_hold", tid), 32'(bus.save_addr),  32'({2'(tid), old_c}));
      check_eq($sformatf("t%0d_c2_busy", tid),         32'(bus.busy_th),      32'(oh));
      @(negedge clk);
      m_cwp[tid] = new_c;
    end
    check_eq($sformatf("t%0d_ack", tid),      32'(bus.ack),     32'(oh));
    check_eq($sformatf("t%0d_ack_busy", tid), 32'(bus.busy_th), 32'(oh));
    check_eq($sformatf("t%0d_ack_save", tid), 32'(bus.save),    32'h0);
    check_eq($sformatf("t%0d_ack_rest", tid), 32'(bus.restore), 32'h0);
    check_eq($sformatf("t%0d_cwp", tid),      32'(bus.cwp),     32'(m_pack()));
    bus.req_vld[tid] = 1'b0;
    @(negedge clk);
    check_quiet($sformatf("t%0d_after", tid));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_ack;
    bus.req_vld = 4'h0;
    bus.req_op  = 8'h00;
    bus.req_cwp = 12'h000;
    rst_l = 1'b0;
    for (int t = 0; t < 4; t++) m_cwp[t] = 3'd0;
    repeat (2) @(negedge clk);
    check_quiet("rst");
    check_eq("rst_save_addr",    32'(bus.save_addr),    32'h0);
    check_eq("rst_restore_addr", 32'(bus.restore_addr), 32'h0);
    check_eq("rst_cwp",          32'(bus.cwp),          32'h000);
    rst_l = 1'b1;
    repeat (4) @(negedge clk);
    check_quiet("idle");
    check_eq("idle_cwp", 32'(bus.cwp), 32'h000);

    op_cycle(2, 2'b11, 3'd3, 3'd0, 3'd3, 1'b1);   // WRCWP t2 -> 3
    op_cycle(2, 2'b01, 3'd0, 3'd3, 3'd4, 1'b1);   // SAVE t2: 3 -> 4
    op_cycle(0, 2'b10, 3'd0, 3'd0, 3'd7, 1'b1);   // RESTORE t0: 0 -> 7 wrap
    op_cycle(1, 2'b11, 3'd0, 3'd0, 3'd0, 1'b0);   // WRCWP t1 to same value
    op_cycle(3, 2'b00, 3'd5, 3'd0, 3'd0, 1'b0);   // reserved op, acked

    // All four threads from reset; thread 0 re-requests right after its ack.
    rst_l = 1'b0;
    for (int t = 0; t < 4; t++) m_cwp[t] = 3'd0;
    @(negedge clk);
    check_eq("rst2_cwp", 32'(bus.cwp), 32'h000);
    rst_l = 1'b1;
    @(negedge clk);
    bus.req_op  = 8'h55;
    bus.req_vld = 4'hf;
    for (int cyc = 1; cyc <= 21; cyc++) begin
      @(negedge clk);
      case (cyc)
        3:       exp_ack = 4'b0001;
        7:       exp_ack = 4'b0010;
        11:      exp_ack = 4'b0100;
        15:      exp_ack = 4'b1000;
        19:      exp_ack = 4'b0001;
        default: exp_ack = 4'b0000;
      endcase
      check_eq($sformatf("rr_ack_c%0d", cyc), 32'(bus.ack), 32'(exp_ack));
      bus.req_vld = bus.req_vld & ~exp_ack;
      if (cyc == 4) bus.req_vld[0] = 1'b1;
    end
    m_cwp[0] = 3'd2; m_cwp[1] = 3'd1; m_cwp[2] = 3'd1; m_cwp[3] = 3'd1;
    check_eq("rr_cwp", 32'(bus.cwp), 32'h24A);

    // Reset during RESTORE aborts the op.
    bus.req_op[5:4] = 2'b01;
    bus.req_vld[2]  = 1'b1;
    @(negedge clk);
    check_eq("abort_c1_save", 32'(bus.save), 32'h1);
    @(negedge clk);
    check_eq("abort_c2_restore",      32'(bus.restore),      32'h1);
    check_eq("abort_c2_restore_addr", 32'(bus.restore_addr), 32'h12);
    #2 rst_l = 1'b0;
    #1;
    check_quiet("abort_async");
    check_eq("abort_save_addr",    32'(bus.save_addr),    32'h0);
    check_eq("abort_restore_addr", 32'(bus.restore_addr), 32'h0);
    check_eq("abort_cwp",          32'(bus.cwp),          32'h000);
    bus.req_vld = 4'h0;
    for (int t = 0; t < 4; t++) m_cwp[t] = 3'd0;
    @(negedge clk);
    rst_l = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      check_eq($sformatf("abort_noack_c%0d", cyc), 32'(bus.ack), 32'h0);
    end
    op_cycle(1, 2'b01, 3'd0, 3'd0, 3'd1, 1'b1);   // SAVE t1: 0 -> 1
    op_cycle(0, 2'b11, 3'd5, 3'd0, 3'd5, 1'b1);   // WRCWP t0 -> 5
    check_eq("final_cwp", 32'(bus.cwp), 32'h00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/irf_window_seq.md
Name: irf_window_seq

Overview:
- Sequences register-window changes for the 4-thread integer register file. The register file holds one live window per thread and a 32-entry backing window store.
- Arbitrates SAVE, RESTORE and write-CWP requests from the 4 threads, round-robin.
- For each granted request, issues a one-cycle save of the current window, then a one-cycle restore of the new window.
- Tracks the per-thread current window pointer (CWP) and stalls the owning thread's register writes for the duration.

Parameters:
- NWIN, 8, windows per thread. Must be a power of two ≤ 8. CWP arithmetic is modulo NWIN.
- RST_CWP, 0, CWP value loaded into every thread at reset.

Ports:
- clk  input  1  core clock; all state on posedge.
- rst_l  input  1  asynchronous active-low reset.
- req_vld  input  4  per-thread request valid. Held until the matching ack.
- req_op  input  8  2 bits per thread, thread t at [2t+1:2t]. 01 = SAVE (CWP+1), 10 = RESTORE (CWP-1), 11 = WRCWP, 00 = reserved (treated as no-op, acked).
- req_cwp  input  12  3 bits per thread: target CWP for WRCWP.
- ack  output  4  one-cycle completion pulse, one-hot.
- busy_th  output  4  thread's live window is in transition. Core must hold that thread's register-file write enable low.
- save  output  1  register-file save strobe.
- save_addr  output  5  {tid[1:0], old_cwp[2:0]}.
- restore  output  1  register-file restore strobe.
- restore_addr  output  5  {tid[1:0], new_cwp[2:0]}.
- cwp  output  12  current CWP per thread, 3 bits each.

Behaviour:
- Reset (async, rst_l=0):
  - state=IDLE; arbiter pointer=thread 0.
  - ack, busy_th, save, restore = 0; save_addr, restore_addr = 0.
  - All cwp fields = RST_CWP.
  - Reset asserted mid-operation aborts the operation: no ack is issued and cwp is not updated.
- All outputs are registered.
- FSM states: IDLE, SAVE, RESTORE, ACK.
- IDLE:
  - If any req_vld is set, grant the first requesting thread at or after the pointer, searching in increasing tid order with wrap.
  - Capture tid, op and new_cwp:
    - SAVE: new_cwp = (cwp+1) mod NWIN.
    - RESTORE: new_cwp = (cwp-1) mod NWIN, so wrap 0 -> NWIN-1.
    - WRCWP: new_cwp = req_cwp[tid] mod NWIN.
  - Pointer <= tid+1 mod 4.
  - If new_cwp == cwp[tid], or op == 00, go to ACK. Otherwise go to SAVE.
- SAVE (1 cycle): save=1, save_addr={tid,cwp[tid]}, busy_th[tid]=1. Next state RESTORE.
- RESTORE (1 cycle): restore=1, restore_addr={tid,new_cwp}, busy_th[tid]=1. cwp[tid] <= new_cwp at the end of this cycle. Next state ACK.
- ACK (1 cycle): ack[tid]=1, busy_th[tid]=1. Next state IDLE. The requester drops req_vld in the cycle after ack.
- Latency: grant at cycle 0. save at cycle 1, restore at cycle 2, ack at cycle 3. Back-to-back grant at cycle 4. The no-change path acks at cycle 1.
- save and restore are never asserted in the same cycle. restore_addr != save_addr for each operation.
- save_addr must still be on the port during RESTORE, because the register file samples it one cycle late. Hold save_addr stable through RESTORE.
- req_vld or req_op changing after grant is ignored; values are captured at grant.
- A requester whose req_vld is set while it is busy is a protocol error. Behaviour in that case is undefined, and a checker flags it.
- No request is lost. Each thread is granted within 4 operations of raising req_vld (round-robin fairness).

Test Plan:
- Reset then no requests -> cwp=12'h000, all outputs 0 indefinitely.
- Thread 2 SAVE with cwp2=3 -> cycle 1 save=1 and save_addr=5'b10_011. Cycle 2 restore=1 and restore_addr=5'b10_100. Cycle 3 ack=4'b0100, cwp2=4. busy_th[2] high in cycles 1-3.
- Thread 0 RESTORE at cwp0=0 -> restore_addr=5'b00_111, cwp0=7 (wrap).
- WRCWP on thread 1 with req_cwp=current value -> ack[1] one cycle after grant; save and restore never asserted.
- All four threads request simultaneously from reset -> grants in order 0,1,2,3, acks at cycles 3,7,11,15. Thread 0 re-requests immediately after its ack -> it is granted after thread 3.
- rst_l pulsed low during the RESTORE state -> outputs 0 asynchronously, no ack, cwp returns to RST_CWP, next request is serviced normally.
